// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Register file for a pipelined LC-3 datapath. It has two combinational read
// ports and one write port, an optional write-to-read bypass and an optional
// hardwired-zero R0. It also keeps a per-register scoreboard of pending writes.
// Decode reserves a write with ISSUE, and writeback retires it with LD_REG.
//
// Ports
//   Clk         in   1      rising-edge clock
//   Reset_n     in   1      asynchronous active-low reset
//   In          in   WIDTH  write data
//   LD_REG      in   1      write enable; also retires one pending write on DR_addr
//   DR_addr     in   AW     write address
//   SR1_addr    in   AW     read port 1 address
//   SR2_addr    in   AW     read port 2 address
//   SR1_out     out  WIDTH  read port 1 data (combinational)
//   SR2_out     out  WIDTH  read port 2 data (combinational)
//   ISSUE       in   1      reserve a pending write to ISSUE_addr
//   ISSUE_addr  in   AW     register being reserved
//   SR1_busy    out  1      SR1_addr still has outstanding writes after bypass
//   SR2_busy    out  1      SR2_addr still has outstanding writes after bypass
//   busy_vec    out  DEPTH  bit i set when the pending count of Ri is non-zero
//   err         out  2      sticky: [0] issue at saturation, [1] retire at count 0
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int MAX_PEND = 3,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_R0  = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] In,
    input  logic             LD_REG,
    input  logic [AW-1:0]    DR_addr,
    input  logic [AW-1:0]    SR1_addr,
    input  logic [AW-1:0]    SR2_addr,
    output logic [WIDTH-1:0] SR1_out,
    output logic [WIDTH-1:0] SR2_out,
    input  logic             ISSUE,
    input  logic [AW-1:0]    ISSUE_addr,
    output logic             SR1_busy,
    output logic             SR2_busy,
    output logic [DEPTH-1:0] busy_vec,
    output logic [1:0]       err
);

    localparam int            CW      = $clog2(MAX_PEND + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PEND);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZRO = {CW{1'b0}};
    localparam logic [AW-1:0] R0_ADDR = {AW{1'b0}};

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [CW-1:0]    cnt_q  [DEPTH];
    logic [CW-1:0]    cnt_d  [DEPTH];
    logic [1:0]       err_q;
    logic [1:0]       err_d;
    logic             inc_s  [DEPTH];
    logic             dec_s  [DEPTH];
    logic             wr_ok_s;
    logic             fwd1_s;
    logic             fwd2_s;
    logic             iss1_s;
    logic             iss2_s;

    // Per-register issue and retire strobes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            inc_s[i] = ISSUE  && (ISSUE_addr == AW'(i));
            dec_s[i] = LD_REG && (DR_addr    == AW'(i));
        end
    end

    // Writes to a hardwired R0 are dropped, and R0 is never forwarded.
    assign wr_ok_s = LD_REG && !(ZERO_R0 && (DR_addr == R0_ADDR));

    // Next state for the data array, the scoreboard counters and the sticky errors.
    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (wr_ok_s) begin
            regs_d[DR_addr] = In;
        end else begin
            regs_d = regs_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (ZERO_R0 && (i == 0)) begin
                cnt_d[i] = CNT_ZRO;
            end else if (inc_s[i] && !dec_s[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    err_d[0] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dec_s[i] && !inc_s[i]) begin
                // The data is still written even when nothing was pending.
                if (cnt_q[i] == CNT_ZRO) begin
                    err_d[1] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_ONE;
                end
            end else begin
                // An issue and a retire in the same cycle cancel, even at the limits.
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
                cnt_q[i]  <= CNT_ZRO;
            end
            err_q <= 2'b00;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Read ports with optional forwarding of the same-cycle write.
    always_comb begin
        fwd1_s = BYPASS && wr_ok_s && (DR_addr == SR1_addr);
        fwd2_s = BYPASS && wr_ok_s && (DR_addr == SR2_addr);
        iss1_s = ISSUE && (ISSUE_addr == SR1_addr);
        iss2_s = ISSUE && (ISSUE_addr == SR2_addr);

        if (fwd1_s) begin
            SR1_out = In;
        end else if (ZERO_R0 && (SR1_addr == R0_ADDR)) begin
            SR1_out = {WIDTH{1'b0}};
        end else begin
            SR1_out = regs_q[SR1_addr];
        end

        if (fwd2_s) begin
            SR2_out = In;
        end else if (ZERO_R0 && (SR2_addr == R0_ADDR)) begin
            SR2_out = {WIDTH{1'b0}};
        end else begin
            SR2_out = regs_q[SR2_addr];
        end

        // The last outstanding write being forwarded now means the value is final.
        if (fwd1_s && (cnt_q[SR1_addr] == CNT_ONE) && !iss1_s) begin
            SR1_busy = 1'b0;
        end else begin
            SR1_busy = (cnt_q[SR1_addr] != CNT_ZRO);
        end

        if (fwd2_s && (cnt_q[SR2_addr] == CNT_ONE) && !iss2_s) begin
            SR2_busy = 1'b0;
        end else begin
            SR2_busy = (cnt_q[SR2_addr] != CNT_ZRO);
        end
    end

    // Busy view built from the registered counters only.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy_vec[i] = (cnt_q[i] != CNT_ZRO);
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb. Three builds share one stimulus stream:
// the default build (bypass on, R0 normal), a build with bypass off, and a
// build with a hardwired-zero R0.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic        Clk;
    logic        Reset_n;
    logic [15:0] In;
    logic        LD_REG;
    logic [2:0]  DR_addr;
    logic [2:0]  SR1_addr;
    logic [2:0]  SR2_addr;
    logic        ISSUE;
    logic [2:0]  ISSUE_addr;

    logic [15:0] a_sr1, a_sr2, b_sr1, b_sr2, z_sr1, z_sr2;
    logic        a_b1, a_b2, b_b1, b_b2, z_b1, z_b2;
    logic [7:0]  a_bv, b_bv, z_bv;
    logic [1:0]  a_err, b_err, z_err;

    int tests;
    int failed;

    reg_file_sb dut (
        .Clk(Clk), .Reset_n(Reset_n), .In(In), .LD_REG(LD_REG), .DR_addr(DR_addr),
        .SR1_addr(SR1_addr), .SR2_addr(SR2_addr), .SR1_out(a_sr1), .SR2_out(a_sr2),
        .ISSUE(ISSUE), .ISSUE_addr(ISSUE_addr), .SR1_busy(a_b1), .SR2_busy(a_b2),
        .busy_vec(a_bv), .err(a_err)
    );

    reg_file_sb #(.BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .Reset_n(Reset_n), .In(In), .LD_REG(LD_REG), .DR_addr(DR_addr),
        .SR1_addr(SR1_addr), .SR2_addr(SR2_addr), .SR1_out(b_sr1), .SR2_out(b_sr2),
        .ISSUE(ISSUE), .ISSUE_addr(ISSUE_addr), .SR1_busy(b_b1), .SR2_busy(b_b2),
        .busy_vec(b_bv), .err(b_err)
    );

    reg_file_sb #(.ZERO_R0(1'b1)) dut_z (
        .Clk(Clk), .Reset_n(Reset_n), .In(In), .LD_REG(LD_REG), .DR_addr(DR_addr),
        .SR1_addr(SR1_addr), .SR2_addr(SR2_addr), .SR1_out(z_sr1), .SR2_out(z_sr2),
        .ISSUE(ISSUE), .ISSUE_addr(ISSUE_addr), .SR1_busy(z_b1), .SR2_busy(z_b2),
        .busy_vec(z_bv), .err(z_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        LD_REG = 1'b0; ISSUE = 1'b0; In = 16'h0000;
        DR_addr = 3'd0; ISSUE_addr = 3'd0;
    endtask

    // Reset pulse placed between clock edges.
    task automatic rst_pulse();
        idle();
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        idle();
        SR1_addr = 3'd0; SR2_addr = 3'd0;

        // Reset held for two cycles.
        Reset_n = 1'b0;
        tick(); tick();
        chk("rst_sr1",  {16'h0, a_sr1}, 32'h0);
        chk("rst_sr2",  {16'h0, a_sr2}, 32'h0);
        chk("rst_bv",   {24'h0, a_bv},  32'h0);
        chk("rst_err",  {30'h0, a_err}, 32'h0);
        Reset_n = 1'b1;

        // Same-cycle write and read of R3.
        tick();
        LD_REG = 1'b1; DR_addr = 3'd3; In = 16'hBEEF; SR1_addr = 3'd3;
        #1;
        chk("byp_sr1",    {16'h0, a_sr1}, 32'h0000BEEF);
        chk("nobyp_sr1",  {16'h0, b_sr1}, 32'h0);
        tick();
        chk("wr_cnt0_err", {30'h0, a_err}, 32'h2);
        idle();
        #1;
        chk("nobyp_next", {16'h0, b_sr1}, 32'h0000BEEF);
        chk("byp_hold",   {16'h0, a_sr1}, 32'h0000BEEF);
        rst_pulse();

        // Scoreboard: two issues to R5, then two retires.
        tick();
        ISSUE = 1'b1; ISSUE_addr = 3'd5;
        tick(); tick();
        idle();
        chk("sb_bv2", {24'h0, a_bv}, 32'h20);
        LD_REG = 1'b1; DR_addr = 3'd5; In = 16'h5555; SR2_addr = 3'd5;
        #1;
        chk("sb_busy_cnt2", {31'h0, a_b2}, 32'h1);
        tick();
        chk("sb_bv1", {24'h0, a_bv}, 32'h20);
        In = 16'h6666;
        #1;
        chk("sb_busy_fwd",   {31'h0, a_b2},  32'h0);
        chk("sb_busy_nobyp", {31'h0, b_b2},  32'h1);
        chk("sb_out_fwd",    {16'h0, a_sr2}, 32'h00006666);
        chk("sb_out_nobyp",  {16'h0, b_sr2}, 32'h00005555);
        tick();
        idle();
        chk("sb_bv0",  {24'h0, a_bv},  32'h0);
        chk("sb_err0", {30'h0, a_err}, 32'h0);
        chk("sb_data", {16'h0, b_sr2}, 32'h00006666);
        rst_pulse();

        // Saturation on R2, then a retire to R1 with nothing pending.
        tick();
        ISSUE = 1'b1; ISSUE_addr = 3'd2;
        tick(); tick(); tick();
        chk("sat_err_at3", {30'h0, a_err}, 32'h0);
        chk("sat_bv",      {24'h0, a_bv},  32'h04);
        tick();
        idle();
        SR1_addr = 3'd2;
        #1;
        chk("sat_err01", {30'h0, a_err}, 32'h1);
        chk("sat_busy",  {31'h0, a_b1},  32'h1);
        LD_REG = 1'b1; DR_addr = 3'd1; In = 16'h0101; SR1_addr = 3'd1;
        tick();
        idle();
        chk("sat_err11", {30'h0, a_err}, 32'h3);
        #1;
        chk("sat_r1",    {16'h0, b_sr1}, 32'h00000101);
        // Two more retires on R2 leave one outstanding, showing the count stuck at 3.
        LD_REG = 1'b1; DR_addr = 3'd2; In = 16'h0202;
        tick(); tick();
        idle();
        chk("sat_left1", {24'h0, a_bv},  32'h04);
        rst_pulse();

        // Simultaneous issue and retire at the limits.
        tick();
        ISSUE = 1'b1; ISSUE_addr = 3'd4;
        tick(); tick(); tick();
        LD_REG = 1'b1; DR_addr = 3'd4; In = 16'h4444;
        tick();
        chk("sim_err_max", {30'h0, a_err}, 32'h0);
        ISSUE_addr = 3'd6; DR_addr = 3'd6; In = 16'h0006;
        tick();
        chk("sim_err_zero", {30'h0, a_err}, 32'h0);
        chk("sim_bv",       {24'h0, a_bv},  32'h10);
        ISSUE = 1'b0; DR_addr = 3'd4; In = 16'h4441;
        tick(); tick();
        chk("sim_still", {24'h0, a_bv}, 32'h10);
        SR1_addr = 3'd4; In = 16'h4440;
        #1;
        chk("sim_last_fwd", {31'h0, a_b1}, 32'h0);
        tick();
        idle();
        chk("sim_drained", {24'h0, a_bv},  32'h0);
        chk("sim_err_end", {30'h0, a_err}, 32'h0);
        rst_pulse();

        // Hardwired-zero R0.
        tick();
        LD_REG = 1'b1; DR_addr = 3'd0; In = 16'h1234; SR1_addr = 3'd0;
        #1;
        chk("z_r0_rd",   {16'h0, z_sr1}, 32'h0);
        chk("a_r0_byp",  {16'h0, a_sr1}, 32'h00001234);
        tick();
        idle();
        chk("z_err_wr",  {30'h0, z_err}, 32'h0);
        chk("a_err_wr",  {30'h0, a_err}, 32'h2);
        ISSUE = 1'b1; ISSUE_addr = 3'd0;
        tick();
        idle();
        chk("z_bv0",     {24'h0, z_bv},  32'h0);
        chk("a_bv0",     {24'h0, a_bv},  32'h01);
        chk("z_err_iss", {30'h0, z_err}, 32'h0);
        chk("z_r0_data", {16'h0, z_sr1}, 32'h0);
        chk("z_r0_busy", {31'h0, z_b1},  32'h0);
        ISSUE = 1'b1; ISSUE_addr = 3'd7;
        tick();
        LD_REG = 1'b1; DR_addr = 3'd7; In = 16'h7777;
        tick();
        idle();
        SR2_addr = 3'd7;
        #1;
        chk("z_r7_bv",   {24'h0, z_bv},  32'h80);
        chk("z_r7_data", {16'h0, z_sr2}, 32'h00007777);
        // Asynchronous reset in the middle of a cycle.
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_data", {16'h0, z_sr2}, 32'h0);
        chk("arst_bv",   {24'h0, z_bv},  32'h0);
        chk("arst_err",  {30'h0, a_err}, 32'h0);
        chk("arst_abv",  {24'h0, a_bv},  32'h0);
        Reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
